// File: rtl/verif_pkg.sv
// Shared definitions for the truth-table verifier: default sizes, FSM encoding
// and the expected-entry lookup.
package verif_pkg;

    localparam int N_IN_DEF  = 5;
    localparam int N_OUT_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        CHECK = ST_CHECK,
        DONE  = ST_DONE
    } state_t;

    // Entry i of the packed table occupies bits [i*N_OUT +: N_OUT].
    function automatic logic [N_OUT_DEF-1:0] exp_slice(
        input logic [N_OUT_DEF*(2**N_IN_DEF)-1:0] tbl,
        input logic [N_IN_DEF-1:0]                idx
    );
        return tbl[int'(idx)*N_OUT_DEF +: N_OUT_DEF];
    endfunction

endpackage

// File: rtl/contador_vectores.sv
// Vector index and settle-window counter; the index stops at the terminal
// vector, it is the FSM that ends the run there.
module contador_vectores
    import verif_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            adv,
    input  logic            tick,
    output logic [N_IN-1:0] idx,
    output logic            settle_done,
    output logic            last
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [N_IN-1:0] idx_q, idx_d;
    logic [SW-1:0]   settle_q, settle_d;

    assign idx         = idx_q;
    assign settle_done = (settle_q == SW'(SETTLE - 1));
    assign last        = (idx_q == {N_IN{1'b1}});

    always_comb begin
        idx_d    = idx_q;
        settle_d = settle_q;
        if (clr) begin
            idx_d    = '0;
            settle_d = '0;
        end else if (adv) begin
            idx_d    = idx_q + N_IN'(1);
            settle_d = '0;
        end else if (tick && !settle_done) begin
            settle_d = settle_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            settle_q <= '0;
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/verificador_tabla_verdad.sv
// Exhaustive truth-table checker: walks every input vector, samples the DUT
// after a settle window and records mismatch count and first failing vector.
module verificador_tabla_verdad
    import verif_pkg::*;
#(
    parameter int                          N_IN     = N_IN_DEF,
    parameter int                          N_OUT    = N_OUT_DEF,
    parameter int                          SETTLE   = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0]  EXPECTED = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err_idx,
    output logic             first_err_valid
);

    localparam int EW = N_IN + 1;

    state_t          state_q, state_d;
    logic [EW-1:0]   err_q, err_d;
    logic [N_IN-1:0] fidx_q, fidx_d;
    logic            fval_q, fval_d;
    logic            pass_q, pass_d;

    logic            clr, adv, tick;
    logic [N_IN-1:0] idx;
    logic            settle_done, last;
    logic [N_OUT-1:0] exp_bits;
    logic            mismatch;

    contador_vectores #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .adv         (adv),
        .tick        (tick),
        .idx         (idx),
        .settle_done (settle_done),
        .last        (last)
    );

    // The package helper is sized for the default geometry; other sizes index directly.
    if (N_IN == N_IN_DEF && N_OUT == N_OUT_DEF) begin : g_pkg_slice
        assign exp_bits = exp_slice(EXPECTED, idx);
    end else begin : g_direct_slice
        assign exp_bits = EXPECTED[int'(idx)*N_OUT +: N_OUT];
    end

    assign mismatch = (dut_out != exp_bits);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fval_d  = fval_q;
        pass_d  = pass_q;
        clr     = 1'b0;
        adv     = 1'b0;
        tick    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = DRIVE;
                    err_d   = '0;
                    fidx_d  = '0;
                    fval_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                tick = 1'b1;
                if (settle_done) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + EW'(1);
                    if (!fval_q) begin
                        fidx_d = idx;
                        fval_d = 1'b1;
                    end
                end
                // pass must include the verdict of the vector checked on this edge.
                if (last) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    adv     = 1'b1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= '0;
            fidx_q  <= '0;
            fval_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fval_q  <= fval_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out         = idx;
    assign busy            = (state_q == DRIVE) || (state_q == CHECK);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fval_q;

endmodule

// File: tb/tb_verificador_tabla_verdad.sv
// Bench for verificador_tabla_verdad: a behavioural DUT model with injectable
// faults feeds the checker; predicted run results are queued and compared at done.
module tb_verificador_tabla_verdad;

    localparam int N_IN    = 5;
    localparam int N_OUT   = 3;
    localparam int SETTLE  = 2;
    localparam int NV      = 2 ** N_IN;
    localparam int RUN_CYC = NV * (SETTLE + 1);

    function automatic logic [N_OUT-1:0] ref_entry(input int i);
        return N_OUT'((i * 5 + 3) ^ (i >> 2));
    endfunction

    function automatic logic [N_OUT*NV-1:0] build_tbl();
        logic [N_OUT*NV-1:0] t;
        t = '0;
        for (int i = 0; i < NV; i++) t[i*N_OUT +: N_OUT] = ref_entry(i);
        return t;
    endfunction

    localparam logic [N_OUT*NV-1:0] EXP_TBL = build_tbl();

    typedef struct packed {
        logic            pass;
        logic [N_IN:0]   err;
        logic [N_IN-1:0] fidx;
        logic            fval;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [N_OUT-1:0] dut_out;
    logic [N_IN-1:0]  vec_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_err_idx;
    logic             first_err_valid;

    int   mode;
    int   total;
    int   bad;
    res_t sb_q[$];

    verificador_tabla_verdad #(
        .N_IN     (N_IN),
        .N_OUT    (N_OUT),
        .SETTLE   (SETTLE),
        .EXPECTED (EXP_TBL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dut_out         (dut_out),
        .vec_out         (vec_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: correct; 1: bit 1 flipped at vector 5; 2: every output inverted.
    always_comb begin
        dut_out = ref_entry(int'(vec_out));
        if (mode == 1 && vec_out == 5'd5) dut_out[1] = ~dut_out[1];
        else if (mode == 2) dut_out = ~dut_out;
    end

    function automatic res_t predict(input int m);
        res_t r;
        logic [N_OUT-1:0] got;
        r = '0;
        for (int i = 0; i < NV; i++) begin
            got = ref_entry(i);
            if (m == 1 && i == 5) got[1] = ~got[1];
            else if (m == 2) got = ~got;
            if (got != ref_entry(i)) begin
                if (!r.fval) begin
                    r.fidx = N_IN'(i);
                    r.fval = 1'b1;
                end
                r.err = r.err + (N_IN+1)'(1);
            end
        end
        r.pass = (r.err == '0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input int m, input bit mid_start);
        res_t e;
        int   k;
        int   seq_bad;
        mode = m;
        sb_q.push_back(predict(m));
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b want=1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL start_done got=%0b want=0", done); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL start_err_clr got=%0d want=0", err_count); end
        total++; if (first_err_valid !== 1'b0) begin bad++; $display("FAIL start_fval_clr got=%0b want=0", first_err_valid); end
        k = 0;
        seq_bad = 0;
        while (done !== 1'b1 && k < RUN_CYC + 20) begin
            if (vec_out !== N_IN'(k / (SETTLE + 1))) seq_bad++;
            start = (mid_start && k == 10 * (SETTLE + 1));
            step();
            k++;
        end
        start = 1'b0;
        total++; if (k != RUN_CYC) begin bad++; $display("FAIL run_latency got=%0d want=%0d", k, RUN_CYC); end
        total++; if (seq_bad != 0) begin bad++; $display("FAIL vec_sequence got=%0d bad cycles want=0", seq_bad); end
        total++; if (vec_out !== N_IN'(NV - 1)) begin bad++; $display("FAIL vec_hold_last got=%0d want=%0d", vec_out, NV - 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%0b want=0", busy); end
        e = sb_q.pop_front();
        total++; if (pass !== e.pass) begin bad++; $display("FAIL pass got=%0b want=%0b", pass, e.pass); end
        total++; if (err_count !== e.err) begin bad++; $display("FAIL err_count got=%0d want=%0d", err_count, e.err); end
        total++; if (first_err_valid !== e.fval) begin bad++; $display("FAIL first_err_valid got=%0b want=%0b", first_err_valid, e.fval); end
        total++; if (first_err_idx !== e.fidx) begin bad++; $display("FAIL first_err_idx got=%0d want=%0d", first_err_idx, e.fidx); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        step();
        step();
        total++; if ({busy, done, pass, first_err_valid} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, pass, first_err_valid}); end
        total++; if (vec_out !== '0) begin bad++; $display("FAIL reset_vec got=%0d want=0", vec_out); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
        total++; if (first_err_idx !== '0) begin bad++; $display("FAIL reset_fidx got=%0d want=0", first_err_idx); end
        rst_n = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%0b want=0", busy); end
    endtask

    task automatic test_clean_run();
        do_run(0, 1'b0);
    endtask

    task automatic test_single_error();
        do_run(1, 1'b0);
    endtask

    task automatic test_all_wrong();
        do_run(2, 1'b0);
    endtask

    task automatic test_mid_start();
        do_run(0, 1'b1);
    endtask

    task automatic test_mid_reset();
        int k;
        mode  = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (vec_out !== 5'd17 && k < RUN_CYC + 20) begin
            step();
            k++;
        end
        total++; if (vec_out !== 5'd17) begin bad++; $display("FAIL reach_idx17 got=%0d want=17", vec_out); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if ({busy, done, pass, first_err_valid} !== 4'b0) begin bad++; $display("FAIL midrst_flags got=%b want=0000", {busy, done, pass, first_err_valid}); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL midrst_err got=%0d want=0", err_count); end
        total++; if (first_err_idx !== '0) begin bad++; $display("FAIL midrst_fidx got=%0d want=0", first_err_idx); end
        total++; if (vec_out !== '0) begin bad++; $display("FAIL midrst_vec got=%0d want=0", vec_out); end
        step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_idle got=%b want=00", {busy, done}); end
        do_run(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_run(1, 1'b0);
        do_run(0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        test_reset();
        test_clean_run();
        test_single_error();
        test_all_wrong();
        test_mid_start();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
